// File: rtl/port_change_detect_pkg.sv
// Shared constants and types for the pin-input peripherals (port, port-change
// detect, interrupt controller).
//   PCD_WIDTH        default port width in bits
//   PCD_SYNC_STAGES  default synchronizer depth (minimum 2)
//   PCD_CHANGE_MASK  default set of bits eligible for interrupt-on-change
//   PCD_INT_BIT      default bit index of the external edge interrupt pin
package port_change_detect_pkg;

  localparam int         PCD_WIDTH       = 8;
  localparam int         PCD_SYNC_STAGES = 2;
  localparam logic [7:0] PCD_CHANGE_MASK = 8'hF0;
  localparam int         PCD_INT_BIT     = 0;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } pcd_state_e;

  // Width of a down-counter that must hold the value n.
  function automatic int pcd_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/port_change_detect_sync_chain.sv
// sync_chain: multi-flop synchronizer for asynchronous pin levels.
//   clk_i   system clock
//   rst_i   synchronous active-high reset, clears every stage
//   data_i  asynchronous pin levels, WIDTH bits
//   data_o  last synchronizer stage, WIDTH bits
module sync_chain #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/port_change_detect.sv
// Port-change and external-edge interrupt detector.
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   physical_in  asynchronous pin levels
//   tris         direction bits, 1 = input
//   port_rd_en   CPU read of the port register this cycle (reloads reference)
//   intedg       edge select for the INT pin, 1 = rising, 0 = falling
//   rbif_clr     software clear of rbif
//   intf_clr     software clear of intf
//   synced       synchronized pin levels
//   rbif         port-change interrupt flag
//   intf         external edge interrupt flag
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_WARMUP | synchronizer filling; ref/prev track synced, flags cannot set
// ST_RUN    | normal detection; stays here until the next reset
module port_change_detect
  import port_change_detect_pkg::*;
#(
  parameter int               WIDTH       = PCD_WIDTH,
  parameter int               SYNC_STAGES = PCD_SYNC_STAGES,
  parameter logic [WIDTH-1:0] CHANGE_MASK = WIDTH'(PCD_CHANGE_MASK),
  parameter int               INT_BIT     = PCD_INT_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] physical_in,
  input  logic [WIDTH-1:0] tris,
  input  logic             port_rd_en,
  input  logic             intedg,
  input  logic             rbif_clr,
  input  logic             intf_clr,
  output logic [WIDTH-1:0] synced,
  output logic             rbif,
  output logic             intf
);

  localparam int CNT_W = pcd_cnt_width(SYNC_STAGES);

  pcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic             prev_q, prev_d;
  logic             rbif_q, rbif_d;
  logic             intf_q, intf_d;

  logic warm;
  logic mismatch;
  logic edge_det;
  logic rbif_set;
  logic intf_set;

  sync_chain #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .data_i(physical_in),
    .data_o(synced)
  );

  assign warm     = (state_q == ST_WARMUP);
  assign mismatch = |((synced ^ ref_q) & CHANGE_MASK & tris);
  assign edge_det = intedg ? (synced[INT_BIT] & ~prev_q) : (~synced[INT_BIT] & prev_q);
  // A read in the same cycle as a mismatch wins: ref reloads and no flag.
  assign rbif_set = ~warm & mismatch & ~port_rd_en;
  assign intf_set = ~warm & edge_det;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    prev_d  = synced[INT_BIT];
    rbif_d  = rbif_q;
    intf_d  = intf_q;

    // Counter starts at SYNC_STAGES, so warm-up covers SYNC_STAGES+1 edges
    // (the last one being the edge at which it reads zero).
    case (state_q)
      ST_WARMUP: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RUN: ;
    endcase

    if (warm || port_rd_en) ref_d = synced;

    if (rbif_set)      rbif_d = 1'b1;
    else if (rbif_clr) rbif_d = 1'b0;

    if (intf_set)      intf_d = 1'b1;
    else if (intf_clr) intf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WARMUP;
      cnt_q   <= CNT_W'(SYNC_STAGES);
      ref_q   <= '0;
      prev_q  <= 1'b0;
      rbif_q  <= 1'b0;
      intf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      prev_q  <= prev_d;
      rbif_q  <= rbif_d;
      intf_q  <= intf_d;
    end
  end

  assign rbif = rbif_q;
  assign intf = intf_q;

endmodule
